// File: rtl/pll_loop_filter_if.sv
// Phase-detector to loop-filter interface.
// The phase detector (master) presents a phase-error sample with a strobe plus
// the run-time gain/hold/clear controls; the loop filter (slave) returns the
// frequency-control word toward the NCO.
// Optional macro: PLL_LOOP_FILTER_RAIL_COUNT_EN adds the rail_count signal.
interface pll_loop_filter_if #(
  parameter int w  = 17,
  parameter int ow = 20
);
  logic [w-1:0]  ang_in;
  logic          strobe_in;
  logic [3:0]    kp_sh;
  logic [3:0]    ki_sh;
  logic          hold;
  logic          clear;
  logic [ow-1:0] freq_out;
  logic          strobe_out;
  logic          railed;
`ifdef PLL_LOOP_FILTER_RAIL_COUNT_EN
  logic [15:0]   rail_count;
`endif

  // Phase-detector side: drives samples and controls, observes the filter output.
  modport master (
    output ang_in, strobe_in, kp_sh, ki_sh, hold, clear,
    input  freq_out, strobe_out, railed
`ifdef PLL_LOOP_FILTER_RAIL_COUNT_EN
    , input rail_count
`endif
  );

  // Loop-filter side: consumes samples and controls, produces the output word.
  modport slave (
    input  ang_in, strobe_in, kp_sh, ki_sh, hold, clear,
    output freq_out, strobe_out, railed
`ifdef PLL_LOOP_FILTER_RAIL_COUNT_EN
    , output rail_count
`endif
  );
endinterface

// File: rtl/pll_loop_filter.sv
// Proportional-integral loop filter for the PLL.
// Three-stage pipeline: capture the phase error, update the saturating
// integrator and form the proportional term, then add and saturate the sum and
// emit its top ow bits as the frequency-control word. Gains are power-of-two
// shifts chosen per sample, so no multipliers are needed.
// Optional macro: PLL_LOOP_FILTER_RAIL_COUNT_EN adds a saturating count of
// railed outputs, zeroed by rst or clear.
module pll_loop_filter #(
  parameter int w  = 17,
  parameter int iw = 32,
  parameter int ow = 20
) (
  input  logic             clk,
  input  logic             rst,
  pll_loop_filter_if.slave pd
);

  // Clamp an iw+1 bit sum back into iw bits; the integrator never wraps.
  function automatic logic [iw-1:0] satIw(input logic [iw:0] x);
    logic [iw-1:0] r;
    if (x[iw] != x[iw-1]) begin
      r = x[iw] ? {1'b1, {(iw-1){1'b0}}} : {1'b0, {(iw-1){1'b1}}};
    end else begin
      r = x[iw-1:0];
    end
    return r;
  endfunction

  // Stage 1 registers: captured sample and its per-sample controls.
  logic          v1_q,     v1_d;
  logic [iw-1:0] e1_q,     e1_d;
  logic [3:0]    kp1_q,    kp1_d;
  logic [3:0]    ki1_q,    ki1_d;
  logic          hold1_q,  hold1_d;

  // Stage 2 registers: proportional term and the integrator itself.
  logic          v2_q,     v2_d;
  logic [iw-1:0] prop2_q,  prop2_d;
  logic [iw-1:0] integ_q,  integ_d;

  // Stage 3 registers: the visible output word and flags.
  logic [ow-1:0] freq_q,   freq_d;
  logic          strobe_q, strobe_d;
  logic          railed_q, railed_d;

  // Intermediate arithmetic.
  logic [iw-1:0] integIncr;
  logic [iw:0]   integWide;
  logic [iw:0]   sumWide;
  logic [iw-1:0] sumSat;
  logic          sumClip;
  logic          sumLowUnused;

  // Stage 1: sign-extend the phase error and latch it with its gains on a strobe.
  always_comb begin
    v1_d    = pd.strobe_in;
    e1_d    = e1_q;
    kp1_d   = kp1_q;
    ki1_d   = ki1_q;
    hold1_d = hold1_q;
    if (pd.strobe_in) begin
      e1_d    = {{(iw-w){pd.ang_in[w-1]}}, pd.ang_in};
      kp1_d   = pd.kp_sh;
      ki1_d   = pd.ki_sh;
      hold1_d = pd.hold;
    end
  end

  // Stage 2: proportional term and saturating integrator; clear beats any update.
  always_comb begin
    v2_d      = v1_q;
    prop2_d   = prop2_q;
    integ_d   = integ_q;
    integIncr = e1_q << ki1_q;
    integWide = {integ_q[iw-1], integ_q} + {integIncr[iw-1], integIncr};
    if (v1_q) begin
      prop2_d = e1_q << kp1_q;
      if (!hold1_q) begin
        integ_d = satIw(integWide);
      end
    end
    if (pd.clear) begin
      integ_d = '0;
    end
  end

  // Stage 3: add the already-updated integrator to the proportional term,
  // saturate, and keep the top ow bits; outputs hold between strobes.
  always_comb begin
    sumWide      = {integ_q[iw-1], integ_q} + {prop2_q[iw-1], prop2_q};
    sumClip      = sumWide[iw] ^ sumWide[iw-1];
    sumSat       = satIw(sumWide);
    sumLowUnused = ^sumSat[iw-ow-1:0];
    strobe_d     = v2_q;
    freq_d       = freq_q;
    railed_d     = railed_q;
    if (v2_q) begin
      freq_d   = sumSat[iw-1:iw-ow];
      railed_d = sumClip;
    end
  end

  // Pipeline register bank; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      e1_q     <= '0;
      kp1_q    <= '0;
      ki1_q    <= '0;
      hold1_q  <= 1'b0;
      v2_q     <= 1'b0;
      prop2_q  <= '0;
      integ_q  <= '0;
      freq_q   <= '0;
      strobe_q <= 1'b0;
      railed_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      e1_q     <= e1_d;
      kp1_q    <= kp1_d;
      ki1_q    <= ki1_d;
      hold1_q  <= hold1_d;
      v2_q     <= v2_d;
      prop2_q  <= prop2_d;
      integ_q  <= integ_d;
      freq_q   <= freq_d;
      strobe_q <= strobe_d;
      railed_q <= railed_d;
    end
  end

  assign pd.freq_out   = freq_q;
  assign pd.strobe_out = strobe_q;
  assign pd.railed     = railed_q;

`ifdef PLL_LOOP_FILTER_RAIL_COUNT_EN
  logic [15:0] railCount_q, railCount_d;

  // Count railed outputs, sticking at all-ones; clear empties it.
  always_comb begin
    railCount_d = railCount_q;
    if (pd.clear) begin
      railCount_d = '0;
    end else if (v2_q && sumClip && (railCount_q != 16'hFFFF)) begin
      railCount_d = railCount_q + 16'd1;
    end
  end

  // Rail counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      railCount_q <= '0;
    end else begin
      railCount_q <= railCount_d;
    end
  end

  assign pd.rail_count = railCount_q;
`endif

endmodule
